// File: rtl/seq_pkg.sv
// Shared definitions for the sequence pattern transmitter and the detector bench.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } state_e;

  // Target sequence of the detector FSM.
  localparam logic [7:0] DEF_PAT = 8'b1110_0011;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register; exposes the bit that follows the current MSB.
module seq_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         next_bit
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  // Rotating keeps every bit live; the owner reloads before each repetition anyway.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = {sr_q[W-2:0], sr_q[W-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign next_bit = sr_q[W-2];

endmodule

// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: sends a latched pattern MSB-first for REPEAT
// repetitions with a one-cycle gap between them, then pulses DONE.
//
// Handshake: START is a request sampled only in IDLE, accepted on the same edge
// (no ready signal); VALID marks each cycle OUT carries a pattern bit; ABORT
// overrides everything and returns the block to IDLE on the next edge.
module seq_pattern_tx #(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = seq_pkg::DEF_PAT
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 USE_DEF,
  input  logic [PAT_W-1:0]     PATTERN,
  input  logic [CNT_W-1:0]     REPEAT,
  output logic                 OUT,
  output logic                 VALID,
  output logic                 BUSY,
  output logic                 DONE,
  output seq_pkg::state_e      DBG_STATE
);

  import seq_pkg::*;

  localparam int               IDX_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_q, out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               piso_load;
  logic               piso_shift;
  logic [PAT_W-1:0]   piso_din;
  logic               piso_next_bit;
  logic [PAT_W-1:0]   pat_sel;

  assign pat_sel = USE_DEF ? DEF_PAT : PATTERN;

  seq_piso #(.W(PAT_W)) u_piso (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (piso_load),
    .shift    (piso_shift),
    .din      (piso_din),
    .next_bit (piso_next_bit)
  );

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    rep_d      = rep_q;
    idx_d      = idx_q;
    out_d      = 1'b0;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_din   = pat_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          pat_d     = pat_sel;
          rep_d     = (REPEAT == '0) ? '0 : REPEAT - CNT_W'(1);
          idx_d     = '0;
          piso_load = 1'b1;
          piso_din  = pat_sel;
          out_d     = pat_sel[PAT_W-1];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (idx_q == LAST_IDX) begin
          if (rep_q != '0) begin
            rep_d   = rep_q - CNT_W'(1);
            busy_d  = 1'b1;
            state_d = GAP;
          end else begin
            done_d  = 1'b1;
            state_d = FIN;
          end
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          piso_shift = 1'b1;
          out_d      = piso_next_bit;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
        end
      end
      GAP: begin
        idx_d     = '0;
        piso_load = 1'b1;
        out_d     = pat_q[PAT_W-1];
        valid_d   = 1'b1;
        busy_d    = 1'b1;
        state_d   = SHIFT;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort discards whatever the state logic decided, including a fresh START.
    if (ABORT) begin
      state_d    = IDLE;
      rep_d      = '0;
      idx_d      = '0;
      out_d      = 1'b0;
      valid_d    = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      piso_load  = 1'b0;
      piso_shift = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign OUT       = out_q;
  assign VALID     = valid_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: per-cycle comparison against a queue-based transfer model.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic       USE_DEF = 1'b0;
  logic [7:0] PATTERN = 8'h00;
  logic [3:0] REPEAT = 4'h0;
  logic       OUT, VALID, BUSY, DONE;
  state_e     dbg_state;

  int checks = 0;
  int errors = 0;

  // Model: one entry {out,valid,busy,done} per upcoming post-edge cycle.
  logic [3:0]  exp_q[$];
  logic [3:0]  cur_exp = 4'b0000;

  logic [31:0] cap = '0;
  int          busy_cnt = 0;
  int          done_cnt = 0;

  seq_pattern_tx dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .ABORT     (ABORT),
    .USE_DEF   (USE_DEF),
    .PATTERN   (PATTERN),
    .REPEAT    (REPEAT),
    .OUT       (OUT),
    .VALID     (VALID),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .DBG_STATE (dbg_state)
  );

  // Clock and watchdog
  initial forever #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_transfer(input logic [7:0] p, input logic [3:0] r);
    int reps;
    reps = (r == 4'd0) ? 1 : int'(r);
    for (int k = 0; k < reps; k++) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back({p[i], 3'b110});
      if (k < reps - 1) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
  endtask

  // Reference model, advanced on every clock edge and on reset assertion.
  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N || ABORT) begin
      exp_q.delete();
      cur_exp = 4'b0000;
    end else begin
      if (START && cur_exp == 4'b0000 && exp_q.size() == 0)
        push_transfer(USE_DEF ? DEF_PAT : PATTERN, REPEAT);
      cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge CLK);
    check("cycle_outs", {28'd0, OUT, VALID, BUSY, DONE}, {28'd0, cur_exp});
    if (VALID) cap = {cap[30:0], OUT};
    busy_cnt += int'(BUSY);
    done_cnt += int'(DONE);
  end

  // Driver tasks
  task automatic step(input logic s, input logic a);
    START = s;
    ABORT = a;
    @(posedge CLK);
    #1;
    START = 1'b0;
    ABORT = 1'b0;
  endtask

  task automatic start_xfer(input logic u, input logic [7:0] p, input logic [3:0] r);
    USE_DEF = u;
    PATTERN = p;
    REPEAT  = r;
    step(1'b1, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(cur_exp == 4'b0000 && exp_q.size() == 0) && n < budget) begin
      step(1'b0, 1'b0);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_stats;
    cap      = '0;
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  initial begin
    // Reset held for three cycles
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outs", {28'd0, OUT, VALID, BUSY, DONE}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    RST_N = 1'b1;
    step(1'b0, 1'b0);

    // Default pattern, single repetition
    clear_stats();
    start_xfer(1'b1, 8'h00, 4'd1);
    wait_idle(40);
    check("def_bits", cap, 32'h0000_00E3);
    check("def_busy", busy_cnt, 32'd8);
    check("def_done", done_cnt, 32'd1);

    // 0xA5 three times with gaps
    clear_stats();
    start_xfer(1'b0, 8'hA5, 4'd3);
    wait_idle(60);
    check("a5x3_bits", cap, 32'h00A5_A5A5);
    check("a5x3_busy", busy_cnt, 32'd26);
    check("a5x3_done", done_cnt, 32'd1);

    // REPEAT=0 behaves as one repetition
    clear_stats();
    start_xfer(1'b0, 8'h81, 4'd0);
    wait_idle(40);
    check("rep0_bits", cap, 32'h0000_0081);
    check("rep0_busy", busy_cnt, 32'd8);

    // START re-pulsed at bit 3 with a different pattern is ignored
    clear_stats();
    start_xfer(1'b0, 8'h3C, 4'd1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    PATTERN = 8'hFF;
    REPEAT  = 4'd5;
    step(1'b1, 1'b0);
    wait_idle(40);
    check("restart_bits", cap, 32'h0000_003C);
    check("restart_done", done_cnt, 32'd1);

    // ABORT at bit 4 of rep 1 of 2, then an immediate new transfer
    clear_stats();
    start_xfer(1'b0, 8'hC3, 4'd2);
    repeat (4) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("abort_outs", {28'd0, OUT, VALID, BUSY, DONE}, 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_no_done", done_cnt, 32'd0);
    start_xfer(1'b0, 8'h5A, 4'd1);
    wait_idle(40);
    check("after_abort_bits", cap, 32'h0000_185A);
    check("after_abort_done", done_cnt, 32'd1);

    // START together with ABORT in IDLE is dropped
    USE_DEF = 1'b0;
    PATTERN = 8'hF0;
    step(1'b1, 1'b1);
    check("start_abort_busy", {31'd0, BUSY}, 32'd0);
    step(1'b0, 1'b0);

    // Asynchronous reset in the middle of a shift
    clear_stats();
    start_xfer(1'b1, 8'h00, 4'd2);
    repeat (3) step(1'b0, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_outs", {28'd0, OUT, VALID, BUSY, DONE}, 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    step(1'b0, 1'b0);
    check("async_rst_no_done", done_cnt, 32'd0);

    // Randomized transfers with stray STARTs, pattern churn and rare aborts
    for (int n = 0; n < 60; n++) begin
      start_xfer(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 3)));
      for (int c = 0; c < 40; c++) begin
        if (cur_exp == 4'b0000 && exp_q.size() == 0) break;
        PATTERN = 8'($urandom);
        REPEAT  = 4'($urandom);
        USE_DEF = 1'($urandom_range(0, 1));
        step(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
      end
      wait_idle(60);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
